// File: rtl/ysyx_2022040010_uncache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_2022040010_uncache_ctrl
// Brief   : Single-outstanding uncached LSU access bridge onto AXI with stall timeout
// Revision: 1.0
// ============================================================================
module ysyx_2022040010_uncache_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [63:0] axi_araddr,
   output logic [2:0]  axi_arsize,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   input  logic [63:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [63:0] axi_awaddr,
   output logic [2:0]  axi_awsize,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   output logic [63:0] axi_wdata,
   output logic [7:0]  axi_wstrb,
   input  logic        axi_bvalid,
   output logic        axi_bready,
   input  logic [1:0]  axi_bresp
);

   localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_up;
   logic [31:0] r_cnt;
   logic        r_wen;
   logic [63:0] r_addr;
   logic [2:0]  r_size;
   logic [63:0] r_wdata;
   logic [7:0]  r_wstrb;
   logic        r_aw_done;
   logic        r_w_done;
   logic [63:0] r_rdata;
   logic        r_err;
   logic        w_timeout;
   logic        w_fin;
   logic        w_err;
   logic [63:0] w_rdata;
   logic        w_bus;

   assign w_timeout  = (c_TIMEOUT != 32'd0) && (r_cnt == c_TIMEOUT);
   assign w_bus      = (r_state == RD_ADDR) || (r_state == RD_DATA) ||
                       (r_state == WR_REQ)  || (r_state == WR_RESP);
   assign axi_araddr = r_addr;
   assign axi_arsize = r_size;
   assign axi_awaddr = r_addr;
   assign axi_awsize = r_size;
   assign axi_wdata  = r_wdata;
   assign axi_wstrb  = r_wstrb;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   always_comb begin
      w_next      = r_state;
      w_fin       = 1'b0;
      w_err       = 1'b0;
      w_rdata     = 64'd0;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      axi_arvalid = 1'b0;
      axi_rready  = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_bready  = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = r_up;
            if (req_valid && r_up) w_next = req_wen ? WR_REQ : RD_ADDR;
         end
         RD_ADDR: begin
            axi_arvalid = 1'b1;
            if (w_timeout) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_err  = 1'b1;
            end else if (axi_arready) begin
               w_next = RD_DATA;
            end
         end
         RD_DATA: begin
            axi_rready = 1'b1;
            // A data beat arriving on the timeout cycle still completes the read.
            if (axi_rvalid) begin
               w_next  = DONE;
               w_fin   = 1'b1;
               w_err   = (axi_rresp != 2'b00);
               w_rdata = (axi_rresp == 2'b00) ? axi_rdata : 64'd0;
            end else if (w_timeout) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_err  = 1'b1;
            end
         end
         WR_REQ: begin
            axi_awvalid = !r_aw_done;
            axi_wvalid  = !r_w_done;
            if (w_timeout) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_err  = 1'b1;
            end else if ((r_aw_done || axi_awready) && (r_w_done || axi_wready)) begin
               w_next = WR_RESP;
            end
         end
         WR_RESP: begin
            axi_bready = 1'b1;
            if (axi_bvalid) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_err  = (axi_bresp != 2'b00);
            end else if (w_timeout) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_err  = 1'b1;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_up      <= 1'b0;
         r_cnt     <= 32'd0;
         r_wen     <= 1'b0;
         r_addr    <= 64'd0;
         r_size    <= 3'd0;
         r_wdata   <= 64'd0;
         r_wstrb   <= 8'd0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_rdata   <= 64'd0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_up    <= 1'b1;
         if (req_valid && req_ready) begin
            r_wen     <= req_wen;
            r_addr    <= req_addr;
            r_size    <= req_size;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_cnt     <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else if (w_bus) begin
            r_cnt <= r_cnt + 32'd1;
         end
         if (axi_awvalid && axi_awready) r_aw_done <= 1'b1;
         if (axi_wvalid && axi_wready)   r_w_done  <= 1'b1;
         if (w_fin) begin
            r_err   <= w_err;
            r_rdata <= r_wen ? 64'd0 : w_rdata;
         end
      end
   end

endmodule
`default_nettype wire
